// File: rtl/brick_pkg.sv
// Shared types and constants for the brick hit detection slice.
package brick_pkg;

    typedef enum logic [1:0] {
        TOP    = 2'b00,
        BOTTOM = 2'b01,
        LEFT   = 2'b10,
        RIGHT  = 2'b11
    } hit_side_t;

    typedef enum logic [1:0] {
        SCAN,
        LATCHED,
        REPORT,
        HOLDOFF
    } hit_state_t;

    localparam int HIT_COUNT_W = 8;
    localparam int OFFSET_W    = 11;

    // A hit on the top or bottom face reverses the vertical velocity.
    function automatic logic isVertical(input hit_side_t side);
        return (side == TOP) || (side == BOTTOM);
    endfunction

endpackage

// File: rtl/hit_side_classifier.sv
// Combinational classifier: maps a brick-relative pixel position to the brick face it lies on.
module hit_side_classifier
    import brick_pkg::*;
#(
    parameter int BRICK_WIDTH_X  = 100,
    parameter int BRICK_HEIGHT_Y = 100,
    parameter int EDGE_PX        = 4
)(
    input  logic [OFFSET_W-1:0] i_offsetX,
    input  logic [OFFSET_W-1:0] i_offsetY,
    output hit_side_t           o_side
);

    // An edge band can never be wider than the brick itself.
    localparam int EDGE_X = (EDGE_PX < BRICK_WIDTH_X) ? EDGE_PX : BRICK_WIDTH_X;

    localparam logic [OFFSET_W-1:0] TOP_LIMIT    = OFFSET_W'(EDGE_PX);
    localparam logic [OFFSET_W-1:0] BOTTOM_LIMIT = OFFSET_W'(BRICK_HEIGHT_Y - EDGE_PX);
    localparam logic [OFFSET_W-1:0] LEFT_LIMIT   = OFFSET_W'(EDGE_X);

    always_comb begin
        o_side = RIGHT;
        if (i_offsetY < TOP_LIMIT) begin
            o_side = TOP;
        end else if (i_offsetY >= BOTTOM_LIMIT) begin
            o_side = BOTTOM;
        end else if (i_offsetX < LEFT_LIMIT) begin
            o_side = LEFT;
        end
    end

endmodule

// File: rtl/brick_hit_detector.sv
// Detects ball/brick overlap, reports one registered collision per hit frame, then ignores hits for a few frames.
// Optional hit counter output enabled by defining BRICK_HIT_COUNT_EN.
module brick_hit_detector
    import brick_pkg::*;
#(
    parameter int BRICK_WIDTH_X  = 100,
    parameter int BRICK_HEIGHT_Y = 100,
    parameter int EDGE_PX        = 4,
    parameter int HOLDOFF_FRAMES = 2
)(
    input  logic                   clk,
    input  logic                   resetN,
    input  logic                   startOfFrame,
    input  logic                   ballDrawingRequest,
    input  logic                   brickDrawingRequest,
    input  logic [OFFSET_W-1:0]    brickOffsetX,
    input  logic [OFFSET_W-1:0]    brickOffsetY,
`ifdef BRICK_HIT_COUNT_EN
    output logic [HIT_COUNT_W-1:0] hitCount,
`endif
    output logic                   collision,
    output logic [1:0]             hitSide,
    output logic                   bounceX,
    output logic                   bounceY
);

    localparam int HOLD_W = (HOLDOFF_FRAMES > 0) ? $clog2(HOLDOFF_FRAMES + 1) : 1;
    localparam logic [HOLD_W-1:0] HOLD_TARGET = HOLD_W'(HOLDOFF_FRAMES);
    localparam logic [HOLD_W-1:0] HOLD_ONE    = HOLD_W'(1);

    hit_state_t        r_state;
    hit_state_t        w_nextState;
    hit_side_t         r_latchedSide;
    hit_side_t         r_hitSide;
    hit_side_t         w_side;
    logic [HOLD_W-1:0] r_holdCount;
    logic              r_collision;
    logic              r_bounceX;
    logic              r_bounceY;
    logic              w_overlap;
    logic              w_holdDone;
    logic              w_enterReport;

    hit_side_classifier #(
        .BRICK_WIDTH_X  (BRICK_WIDTH_X),
        .BRICK_HEIGHT_Y (BRICK_HEIGHT_Y),
        .EDGE_PX        (EDGE_PX)
    ) u_classifier (
        .i_offsetX (brickOffsetX),
        .i_offsetY (brickOffsetY),
        .o_side    (w_side)
    );

    // The first pixel of a frame is blanking, so it never counts as an overlap.
    assign w_overlap     = ballDrawingRequest & brickDrawingRequest & ~startOfFrame;
    assign w_holdDone    = startOfFrame && (HOLD_W'(r_holdCount + HOLD_ONE) == HOLD_TARGET);
    assign w_enterReport = (r_state == LATCHED) && startOfFrame;

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_state <= SCAN;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            SCAN:    if (w_overlap) w_nextState = LATCHED;
            LATCHED: if (startOfFrame) w_nextState = REPORT;
            REPORT:  w_nextState = (HOLDOFF_FRAMES == 0) ? SCAN : HOLDOFF;
            HOLDOFF: if (w_holdDone) w_nextState = SCAN;
            default: w_nextState = SCAN;
        endcase
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_latchedSide <= TOP;
            r_holdCount   <= '0;
        end else begin
            if ((r_state == SCAN) && w_overlap) begin
                r_latchedSide <= w_side;
            end
            if (r_state != HOLDOFF) begin
                r_holdCount <= '0;
            end else if (startOfFrame) begin
                if (w_holdDone) begin
                    r_holdCount <= '0;
                end else if (r_holdCount != HOLD_TARGET) begin
                    r_holdCount <= r_holdCount + HOLD_ONE;
                end
            end
        end
    end

    // Outputs are loaded on the edge that enters REPORT, so they are high exactly during REPORT.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_collision <= 1'b0;
            r_bounceX   <= 1'b0;
            r_bounceY   <= 1'b0;
            r_hitSide   <= TOP;
        end else begin
            r_collision <= w_enterReport;
            r_bounceY   <= w_enterReport && isVertical(r_latchedSide);
            r_bounceX   <= w_enterReport && !isVertical(r_latchedSide);
            if (w_enterReport) begin
                r_hitSide <= r_latchedSide;
            end
        end
    end

`ifdef BRICK_HIT_COUNT_EN
    logic [HIT_COUNT_W-1:0] r_hitCount;

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_hitCount <= '0;
        end else if (w_enterReport && (r_hitCount != {HIT_COUNT_W{1'b1}})) begin
            r_hitCount <= r_hitCount + 1'b1;
        end
    end

    assign hitCount = r_hitCount;
`endif

    assign collision = r_collision;
    assign hitSide   = r_hitSide;
    assign bounceX   = r_bounceX;
    assign bounceY   = r_bounceY;

endmodule

// File: tb/tb_brick_hit_detector.sv
// Self-checking bench for brick_hit_detector: directed vector table, hand-written corner sequences
// and randomized frames checked against a frame-level reference model.
module tb_brick_hit_detector;

    localparam int HOLDOFF   = 2;
    localparam int HEIGHT    = 100;
    localparam int WIDTH     = 100;
    localparam int EDGE      = 4;
    localparam int FRAME_LEN = 12;
    localparam int RAND_FRAMES = 250;

    logic        clk;
    logic        resetN;
    logic        startOfFrame;
    logic        ballDrawingRequest;
    logic        brickDrawingRequest;
    logic [10:0] brickOffsetX;
    logic [10:0] brickOffsetY;
    logic        collision;
    logic [1:0]  hitSide;
    logic        bounceX;
    logic        bounceY;
`ifdef BRICK_HIT_COUNT_EN
    logic [7:0]  hitCount;
`endif

    int checks = 0;
    int errors = 0;

    typedef struct {
        bit sof;
        bit ball;
        bit brick;
        int x;
        int y;
        bit expColl;
        int expSide;
        bit expBx;
        bit expBy;
    } vector_t;

    vector_t vecs[$];

    brick_hit_detector #(
        .BRICK_WIDTH_X  (WIDTH),
        .BRICK_HEIGHT_Y (HEIGHT),
        .EDGE_PX        (EDGE),
        .HOLDOFF_FRAMES (HOLDOFF)
    ) dut (
        .clk                 (clk),
        .resetN              (resetN),
        .startOfFrame        (startOfFrame),
        .ballDrawingRequest  (ballDrawingRequest),
        .brickDrawingRequest (brickDrawingRequest),
        .brickOffsetX        (brickOffsetX),
        .brickOffsetY        (brickOffsetY),
`ifdef BRICK_HIT_COUNT_EN
        .hitCount            (hitCount),
`endif
        .collision           (collision),
        .hitSide             (hitSide),
        .bounceX             (bounceX),
        .bounceY             (bounceY)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #10000000;
        $display("[TB] FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Face a pixel belongs to: 0 top, 1 bottom, 2 left, 3 right.
    function automatic int classify(input int x, input int y);
        if (y < EDGE) return 0;
        if (y >= HEIGHT - EDGE) return 1;
        if (x < EDGE) return 2;
        return 3;
    endfunction

    task automatic applyStimulus(input bit s, input bit b, input bit k, input int x, input int y);
        @(negedge clk);
        startOfFrame        = s;
        ballDrawingRequest  = b;
        brickDrawingRequest = k;
        brickOffsetX        = 11'(x);
        brickOffsetY        = 11'(y);
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%0d expected=%0d", name, actual, expected);
        end
    endtask

    task automatic checkAll(input string tag, input bit c, input int side, input bit bx, input bit by);
        checkOutput({tag, ".collision"}, int'(collision), int'(c));
        checkOutput({tag, ".hitSide"},   int'(hitSide),   side);
        checkOutput({tag, ".bounceX"},   int'(bounceX),   int'(bx));
        checkOutput({tag, ".bounceY"},   int'(bounceY),   int'(by));
    endtask

    task automatic doReset();
        @(negedge clk);
        resetN              = 1'b0;
        startOfFrame        = 1'b0;
        ballDrawingRequest  = 1'b0;
        brickDrawingRequest = 1'b0;
        brickOffsetX        = '0;
        brickOffsetY        = '0;
        repeat (2) @(posedge clk);
        #1;
        checkAll("reset", 1'b0, 0, 1'b0, 1'b0);
        @(negedge clk);
        resetN = 1'b1;
    endtask

    task automatic addVec(input bit s, input bit b, input bit k, input int x, input int y,
                          input bit c, input int side, input bit bx, input bit by);
        vector_t v;
        v.sof = s; v.ball = b; v.brick = k; v.x = x; v.y = y;
        v.expColl = c; v.expSide = side; v.expBx = bx; v.expBy = by;
        vecs.push_back(v);
    endtask

    initial begin
        int pending;
        int pendingSide;
        int lastSide;
        int blocked;
        bit justReported;
        bit report;
        bit s, b, k;
        int x, y;

        resetN              = 1'b0;
        startOfFrame        = 1'b0;
        ballDrawingRequest  = 1'b0;
        brickDrawingRequest = 1'b0;
        brickOffsetX        = '0;
        brickOffsetY        = '0;

        // Directed table: top hit, side priority, holdoff discards, blanking, left and right hits.
        addVec(1, 0, 0,  0,  0, 0, 0, 0, 0);
        addVec(0, 1, 1, 50,  1, 0, 0, 0, 0);
        addVec(0, 0, 0,  0,  0, 0, 0, 0, 0);
        addVec(1, 0, 0,  0,  0, 1, 0, 0, 1);
        addVec(0, 0, 0,  0,  0, 0, 0, 0, 0);
        addVec(0, 1, 1,  2, 98, 0, 0, 0, 0);
        addVec(1, 0, 0,  0,  0, 0, 0, 0, 0);
        addVec(0, 1, 1,  2, 98, 0, 0, 0, 0);
        addVec(1, 0, 0,  0,  0, 0, 0, 0, 0);
        addVec(0, 1, 1,  2, 98, 0, 0, 0, 0);
        addVec(0, 1, 1, 50, 50, 0, 0, 0, 0);
        addVec(1, 0, 0,  0,  0, 1, 1, 0, 1);
        addVec(0, 0, 0,  0,  0, 0, 1, 0, 0);
        addVec(1, 0, 0,  0,  0, 0, 1, 0, 0);
        addVec(1, 0, 0,  0,  0, 0, 1, 0, 0);
        addVec(1, 1, 1,  0, 50, 0, 1, 0, 0);
        addVec(0, 0, 0,  0,  0, 0, 1, 0, 0);
        addVec(1, 0, 0,  0,  0, 0, 1, 0, 0);
        addVec(0, 1, 1,  0, 50, 0, 1, 0, 0);
        addVec(1, 0, 0,  0,  0, 1, 2, 1, 0);
        addVec(0, 0, 0,  0,  0, 0, 2, 0, 0);
        addVec(1, 0, 0,  0,  0, 0, 2, 0, 0);
        addVec(1, 0, 0,  0,  0, 0, 2, 0, 0);
        addVec(0, 1, 1, 99, 50, 0, 2, 0, 0);
        addVec(1, 0, 0,  0,  0, 1, 3, 1, 0);
        addVec(0, 0, 0,  0,  0, 0, 3, 0, 0);

        doReset();
        foreach (vecs[i]) begin
            applyStimulus(vecs[i].sof, vecs[i].ball, vecs[i].brick, vecs[i].x, vecs[i].y);
            checkAll($sformatf("vec%0d", i), vecs[i].expColl, vecs[i].expSide, vecs[i].expBx, vecs[i].expBy);
        end

        // Holdoff: overlaps in four consecutive frames, pulses only after frames 1 and 4.
        doReset();
        for (int f = 0; f <= 4; f++) begin
            applyStimulus(1, 0, 0, 0, 0);
            checkOutput($sformatf("holdoff.sof%0d.collision", f), int'(collision),
                        (f == 1 || f == 4) ? 1 : 0);
            if (f < 4) begin
                applyStimulus(0, 1, 1, 50, 50);
                applyStimulus(0, 0, 0, 0, 0);
                applyStimulus(0, 0, 0, 0, 0);
            end
        end

        // Reset while LATCHED discards the pending right-side hit.
        doReset();
        applyStimulus(1, 0, 0, 0, 0);
        applyStimulus(0, 1, 1, 99, 50);
        applyStimulus(0, 0, 0, 0, 0);
        #2 resetN = 1'b0;
        #1 checkAll("midReset.asserted", 1'b0, 0, 1'b0, 1'b0);
        @(negedge clk);
        resetN = 1'b1;
        applyStimulus(1, 0, 0, 0, 0);
        checkAll("midReset.sof", 1'b0, 0, 1'b0, 1'b0);
        applyStimulus(0, 0, 0, 0, 0);
        checkAll("midReset.after", 1'b0, 0, 1'b0, 1'b0);

        // First overlap after release is accepted; then reset clears a live pulse asynchronously.
        applyStimulus(0, 1, 1, 50, 1);
        applyStimulus(1, 0, 0, 0, 0);
        checkAll("postReset.hit", 1'b1, 0, 1'b0, 1'b1);
        #2 resetN = 1'b0;
        #1 checkAll("asyncReset", 1'b0, 0, 1'b0, 1'b0);
        @(negedge clk);
        resetN = 1'b1;

        // Randomized frames against a frame-level model.
        doReset();
        pending      = 0;
        pendingSide  = 0;
        lastSide     = 0;
        blocked      = 0;
        justReported = 1'b0;
        for (int f = 0; f < RAND_FRAMES; f++) begin
            for (int c = 0; c < FRAME_LEN; c++) begin
                s = (c == 0);
                b = ($urandom_range(0, 3) == 0);
                k = ($urandom_range(0, 1) == 1);
                x = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 2047)) : int'($urandom_range(0, 99));
                y = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 2047)) : int'($urandom_range(0, 99));
                report = 1'b0;
                if (s) begin
                    if (pending != 0) begin
                        report       = 1'b1;
                        lastSide     = pendingSide;
                        pending      = 0;
                        blocked      = HOLDOFF;
                        justReported = 1'b1;
                    end else if (blocked > 0) begin
                        blocked--;
                    end
                end else begin
                    if (b && k && blocked == 0 && pending == 0 && !(c == 1 && justReported)) begin
                        pending     = 1;
                        pendingSide = classify(x, y);
                    end
                    if (c == 1) justReported = 1'b0;
                end
                applyStimulus(s, b, k, x, y);
                checkAll($sformatf("rand.f%0d.c%0d", f, c), report, lastSide,
                         report && (lastSide >= 2), report && (lastSide < 2));
            end
        end

`ifdef BRICK_HIT_COUNT_EN
        // Saturating hit counter over 300 well-spaced hits.
        doReset();
        checkOutput("hitCount.reset", int'(hitCount), 0);
        for (int h = 0; h < 300; h++) begin
            applyStimulus(0, 1, 1, 50, 50);
            applyStimulus(1, 0, 0, 0, 0);
            applyStimulus(0, 0, 0, 0, 0);
            applyStimulus(1, 0, 0, 0, 0);
            applyStimulus(1, 0, 0, 0, 0);
            if (h == 9) checkOutput("hitCount.ten", int'(hitCount), 10);
        end
        checkOutput("hitCount.saturated", int'(hitCount), 255);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
